exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits, legal range 8 to 64.
REQ-002 The block SHALL have parameter RADDR, default 5, register-index width in bits.
REQ-003 The block SHALL be clocked by one clock `clk`, and reset SHALL be synchronous and active-high on `rst`.
REQ-004 Port list, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  issue-slot valid
- flush  in  1  kill the in-flight op and the output register
- alu_op  in  3  operation select
- rd1, rd2  in  WIDTH  register-file operands
- imm  in  WIDTH  sign-extended immediate
- fwd_mem, fwd_wb  in  WIDTH  forwarded MEM and WB data
- fsel1, fsel2  in  2  forward selects
- alu_src  in  1  1 = imm replaces operand B
- reg_dst  in  1  destination select
- rt, rd  in  RADDR  candidate destinations
- stall  out  1  upstream must hold its issue slot
- out_valid  out  1  output register holds a valid result
- alu_res  out  WIDTH  registered result
- store_data  out  WIDTH  registered forwarded operand B, before the imm mux
- dest  out  RADDR  registered destination
- zero  out  1  registered alu_res == 0

Function
REQ-005 Operand select for fselN SHALL be: 00 = rdN, 01 = fwd_mem, 10 = fwd_wb, 11 = rdN.
REQ-006 Operand A SHALL be fwd1; operand B SHALL be imm when alu_src = 1, otherwise fwd2.
REQ-007 dest SHALL be rt when reg_dst = 0 and rd when reg_dst = 1.
REQ-008 alu_op encoding SHALL be:
- 000 AND
- 001 OR
- 010 ADD, mod 2^WIDTH
- 011 SUB, mod 2^WIDTH
- 100 SLT, signed, result 1 or 0 zero-extended
- 101 XOR
- 110 NOR
- 111 MUL, low WIDTH bits of the unsigned product
REQ-009 FSM states SHALL be IDLE and MUL.
REQ-010 In IDLE, in_valid with a non-MUL op SHALL load alu_res, store_data, dest and zero at the next edge, and set out_valid = 1 (1-cycle latency).
REQ-011 In IDLE, in_valid with op 111 SHALL do all of the following:
- latch operand A, operand B, dest and store_data
- load cycle counter = WIDTH-1
- go to MUL
- set out_valid = 0 at that edge
REQ-012 In MUL, the block SHALL do one shift-add step per cycle and decrement the counter.
REQ-013 When the counter is 0, the block SHALL load the product into alu_res, set out_valid = 1, and return to IDLE; total latency from issue edge to out_valid SHALL be WIDTH+1 edges.
REQ-014 stall SHALL be combinational.
REQ-015 stall SHALL be 1 in IDLE when in_valid = 1 and alu_op = 111.
REQ-016 stall SHALL be 1 throughout MUL except in the final cycle (counter = 0), where it SHALL be 0.
REQ-017 Inputs SHALL be ignored while in MUL.
REQ-018 In IDLE with in_valid = 0, out_valid SHALL go to 0 at the next edge; the other outputs SHALL hold.
REQ-019 flush SHALL force state IDLE and out_valid = 0 at the next edge, abandon any multiply, and ignore in_valid in the same cycle; the data outputs SHALL hold.
REQ-020 If flush and the final MUL cycle coincide, flush SHALL win and no result SHALL be published.
REQ-021 The zero output SHALL be computed from the value actually written to alu_res.

Reset
REQ-022 When rst = 1 at an edge, the block SHALL set state = IDLE, counter = 0, out_valid = 0, alu_res = 0, store_data = 0, dest = 0 and zero = 1; stall SHALL evaluate as in IDLE.
REQ-023 rst SHALL have priority over flush and in_valid, and a reset during MUL SHALL discard the partial product.

Verification (WIDTH = 32)
REQ-024 ADD with rd1 = 5, rd2 = 7, fsel = 00/00, alu_src = 0 SHALL give, next edge: alu_res = 12, zero = 0, out_valid = 1.
REQ-025 SUB with fsel1 = 01, fwd_mem = 9, imm = 9, alu_src = 1 SHALL give alu_res = 0, zero = 1; store_data SHALL equal rd2, not imm.
REQ-026 SLT with A = 0xFFFFFFFF, B = 1 SHALL give alu_res = 1; XOR 0xFF00FF00 with 0x0F0F0F0F SHALL give 0xF00FF00F.
REQ-027 MUL 0x10000 × 0x10001 SHALL give:
- stall high for 32 cycles, then low in the final cycle
- out_valid = 1 exactly 33 edges after issue
- alu_res = 0x00010000
REQ-028 MUL issued, then flush at cycle 10 SHALL give state IDLE, out_valid = 0, and no result; an ADD issued next SHALL complete in 1 cycle.
REQ-029 rst asserted mid-MUL with in_valid = 1 SHALL give all outputs at reset values next edge and stall = 0 when in_valid = 0.

Source files
------------

// File: rtl/exec_unit_if.sv
// rtl/exec_unit_if.sv - issue-slot and result bundle between the upstream pipeline and exec_unit
interface exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic             flush;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] fwd_mem;
    logic [WIDTH-1:0] fwd_wb;
    logic [1:0]       fsel1;
    logic [1:0]       fsel2;
    logic             alu_src;
    logic             reg_dst;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] rd;
    logic             stall;
    logic             out_valid;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] store_data;
    logic [RADDR-1:0] dest;
    logic             zero;

    // upstream side: presents the issue slot, observes stall and the result register
    modport master (
        output in_valid, flush, alu_op, rd1, rd2, imm, fwd_mem, fwd_wb,
               fsel1, fsel2, alu_src, reg_dst, rt, rd,
        input  stall, out_valid, alu_res, store_data, dest, zero
    );

    // execution unit side
    modport slave (
        input  in_valid, flush, alu_op, rd1, rd2, imm, fwd_mem, fwd_wb,
               fsel1, fsel2, alu_src, reg_dst, rt, rd,
        output stall, out_valid, alu_res, store_data, dest, zero
    );
endinterface

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - single-issue ALU with operand forwarding and a WIDTH-cycle shift-add multiplier
module exec_unit #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic        clk,
    input  logic        rst,
    exec_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] fwd2;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] mul_next;
    logic [RADDR-1:0] dest_sel;

    // forwarding muxes; select 11 falls back to the register file like 00
    always_comb begin
        op_a = bus.rd1;
        case (bus.fsel1)
            2'b01:   op_a = bus.fwd_mem;
            2'b10:   op_a = bus.fwd_wb;
            default: op_a = bus.rd1;
        endcase
        fwd2 = bus.rd2;
        case (bus.fsel2)
            2'b01:   fwd2 = bus.fwd_mem;
            2'b10:   fwd2 = bus.fwd_wb;
            default: fwd2 = bus.rd2;
        endcase
        op_b     = bus.alu_src ? bus.imm : fwd2;
        dest_sel = bus.reg_dst ? bus.rd : bus.rt;
    end

    // single-cycle ALU; the MUL encoding is handled by the sequential multiplier
    always_comb begin
        alu_val = '0;
        case (bus.alu_op)
            OP_AND:  alu_val = op_a & op_b;
            OP_OR:   alu_val = op_a | op_b;
            OP_ADD:  alu_val = op_a + op_b;
            OP_SUB:  alu_val = op_a - op_b;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_XOR:  alu_val = op_a ^ op_b;
            OP_NOR:  alu_val = ~(op_a | op_b);
            default: alu_val = '0;
        endcase
    end

    // one shift-add step: accumulate the multiplicand when the current multiplier bit is set
    always_comb begin
        mul_next = acc + (mplier[0] ? mcand : '0);
    end

    // hold the issue slot while a multiply is being accepted or is still iterating;
    // the last iteration releases it so the next op can be presented when IDLE returns
    assign bus.stall = ((state == IDLE) && bus.in_valid && (bus.alu_op == OP_MUL)) ||
                       ((state == MUL) && (cnt != '0));

    // control FSM and result register; reset beats flush, flush beats issue and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            bus.out_valid  <= 1'b0;
            bus.alu_res    <= '0;
            bus.store_data <= '0;
            bus.dest       <= '0;
            bus.zero       <= 1'b1;
        end else if (bus.flush) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.store_data <= fwd2;
                        bus.dest       <= dest_sel;
                        if (bus.alu_op == OP_MUL) begin
                            mcand         <= op_a;
                            mplier        <= op_b;
                            acc           <= '0;
                            cnt           <= CW'(WIDTH - 1);
                            state         <= MUL;
                            bus.out_valid <= 1'b0;
                        end else begin
                            bus.alu_res   <= alu_val;
                            bus.zero      <= (alu_val == '0);
                            bus.out_valid <= 1'b1;
                        end
                    end else begin
                        bus.out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        bus.alu_res   <= mul_next;
                        bus.zero      <= (mul_next == '0);
                        bus.out_valid <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        acc    <= mul_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed and randomized self-checking bench for exec_unit
module tb_exec_unit;
    localparam int WIDTH = 32;
    localparam int RADDR = 5;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    logic [WIDTH-1:0] exp_res;
    logic [WIDTH-1:0] exp_sd;
    logic [RADDR-1:0] exp_dest;
    logic             exp_ov;
    logic             exp_zero;

    exec_unit_if #(.WIDTH(WIDTH), .RADDR(RADDR)) bus ();

    exec_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(exp_ov));
        check({tag, "_alu_res"}, 64'(bus.alu_res), 64'(exp_res));
        check({tag, "_store_data"}, 64'(bus.store_data), 64'(exp_sd));
        check({tag, "_dest"}, 64'(bus.dest), 64'(exp_dest));
        check({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick(input logic [1:0] sel, input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return WIDTH'(64'(a) + 64'(b));
            3'd3: return WIDTH'(64'(a) - 64'(b));
            3'd4: return (sa < sb) ? WIDTH'(1) : WIDTH'(0);
            3'd5: return a ^ b;
            3'd6: return ~(a | b);
            default: return WIDTH'(64'(a) * 64'(b));
        endcase
    endfunction

    task automatic rand_inputs(input bit allow_mul);
        bus.in_valid = 1'($urandom);
        bus.flush    = ($urandom_range(0, 7) == 0);
        bus.alu_op   = allow_mul ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
        bus.rd1      = $urandom;
        bus.rd2      = $urandom;
        bus.imm      = $urandom;
        bus.fwd_mem  = $urandom;
        bus.fwd_wb   = $urandom;
        bus.fsel1    = 2'($urandom);
        bus.fsel2    = 2'($urandom);
        bus.alu_src  = 1'($urandom);
        bus.reg_dst  = 1'($urandom);
        bus.rt       = RADDR'($urandom);
        bus.rd       = RADDR'($urandom);
    endtask

    task automatic set_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b0;
        bus.alu_op   = op;
        bus.rd1      = a;
        bus.rd2      = b;
        bus.fsel1    = 2'd0;
        bus.fsel2    = 2'd0;
        bus.alu_src  = 1'b0;
        bus.reg_dst  = 1'($urandom);
        bus.rt       = RADDR'($urandom);
        bus.rd       = RADDR'($urandom);
        bus.imm      = $urandom;
    endtask

    // one edge in IDLE with a non-multiply slot; the model decides what the edge publishes
    task automatic idle_op(input string tag);
        logic [WIDTH-1:0] a, f2, b, r;
        a  = pick(bus.fsel1, bus.rd1, bus.fwd_mem, bus.fwd_wb);
        f2 = pick(bus.fsel2, bus.rd2, bus.fwd_mem, bus.fwd_wb);
        b  = bus.alu_src ? bus.imm : f2;
        if (bus.flush) begin
            exp_ov = 1'b0;
        end else if (bus.in_valid) begin
            r        = ref_alu(bus.alu_op, a, b);
            exp_res  = r;
            exp_zero = (r == '0);
            exp_sd   = f2;
            exp_dest = bus.reg_dst ? bus.rd : bus.rt;
            exp_ov   = 1'b1;
        end else begin
            exp_ov = 1'b0;
        end
        #1;
        check({tag, "_stall"}, 64'(bus.stall), 64'(0));
        tick();
        check_outputs(tag);
    endtask

    // issue a multiply from IDLE and follow it cycle by cycle; flush_at = 0 means no flush
    task automatic run_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int flush_at);
        logic [WIDTH-1:0] prod;
        int stall_hi;
        set_op(3'd7, a, b);
        prod     = ref_alu(3'd7, a, b);
        exp_sd   = b;
        exp_dest = bus.reg_dst ? bus.rd : bus.rt;
        #1;
        check({tag, "_stall_issue"}, 64'(bus.stall), 64'(1));
        stall_hi = bus.stall ? 1 : 0;
        tick();
        exp_ov = 1'b0;
        check_outputs({tag, "_issue"});
        for (int k = 1; k <= WIDTH; k++) begin
            rand_inputs(1'b1);
            bus.flush = (k == flush_at);
            #1;
            check({tag, "_stall_mul"}, 64'(bus.stall), 64'(k < WIDTH));
            if (bus.stall) stall_hi++;
            tick();
            if (k == flush_at) begin
                exp_ov = 1'b0;
                check_outputs({tag, "_flushed"});
                break;
            end else if (k == WIDTH) begin
                exp_ov   = 1'b1;
                exp_res  = prod;
                exp_zero = (prod == '0);
                check_outputs({tag, "_done"});
                check({tag, "_stall_cycles"}, 64'(stall_hi), 64'(WIDTH));
            end else begin
                check({tag, "_busy_ov"}, 64'(bus.out_valid), 64'(0));
            end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rand_inputs(1'b0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        tick();
        tick();
        exp_ov = 1'b0; exp_res = '0; exp_sd = '0; exp_dest = '0; exp_zero = 1'b1;
        check_outputs("reset");
        check("reset_stall", 64'(bus.stall), 64'(0));
        rst = 1'b0;

        // directed ALU cases
        set_op(3'd2, 32'd5, 32'd7);
        idle_op("add");
        check("add_res_const", 64'(bus.alu_res), 64'd12);

        set_op(3'd3, 32'h0000_1234, 32'h0000_1234);
        bus.rd2 = 32'h0000_1234; bus.fsel1 = 2'd1; bus.fwd_mem = 32'd9;
        bus.imm = 32'd9; bus.alu_src = 1'b1;
        idle_op("sub");
        check("sub_zero_const", 64'(bus.zero), 64'd1);
        check("sub_store_const", 64'(bus.store_data), 64'h1234);

        set_op(3'd4, 32'hFFFF_FFFF, 32'd1);
        idle_op("slt");
        check("slt_res_const", 64'(bus.alu_res), 64'd1);

        set_op(3'd5, 32'hFF00_FF00, 32'h0F0F_0F0F);
        idle_op("xor");
        check("xor_res_const", 64'(bus.alu_res), 64'hF00F_F00F);

        bus.in_valid = 1'b0;
        idle_op("idle_hold");

        set_op(3'd1, $urandom, $urandom);
        bus.flush = 1'b1;
        idle_op("flush_idle");

        for (int i = 0; i < 60; i++) begin
            rand_inputs(1'b0);
            idle_op("rand_alu");
        end

        run_mul("mul_dir", 32'h0001_0000, 32'h0001_0001, 0);
        check("mul_dir_const", 64'(bus.alu_res), 64'h0001_0000);

        run_mul("mul_flush10", $urandom, $urandom, 10);
        #1;
        check("post_flush_stall", 64'(bus.stall), 64'(0));
        set_op(3'd2, $urandom, $urandom);
        idle_op("add_after_flush");

        run_mul("mul_flush_last", $urandom, $urandom, WIDTH);
        bus.in_valid = 1'b0;
        idle_op("after_flush_last");

        for (int i = 0; i < 4; i++) begin
            run_mul("mul_rand", $urandom, $urandom, 0);
            rand_inputs(1'b0);
            idle_op("rand_between");
        end
        run_mul("mul_zero", 32'd0, $urandom, 0);

        // reset in the middle of a multiply, with a new multiply being offered
        set_op(3'd7, $urandom, $urandom);
        tick();
        for (int i = 0; i < 5; i++) begin
            rand_inputs(1'b1);
            bus.flush = 1'b0;
            tick();
        end
        rst = 1'b1;
        set_op(3'd7, $urandom, $urandom);
        tick();
        exp_ov = 1'b0; exp_res = '0; exp_sd = '0; exp_dest = '0; exp_zero = 1'b1;
        check_outputs("mid_mul_reset");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_mul_reset_stall", 64'(bus.stall), 64'(0));
        idle_op("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
